// File: rtl/angle_sensor_poller.sv
// Polls a set of SPI angle sensors in ascending index order, once per sweep period.
// Each reply is checked before it is stored. Bad or missing replies raise sticky per-sensor errors.
module angle_sensor_poller #(
  parameter int unsigned NUMBER_OF_SENSORS = 9,
  parameter int unsigned SETUP_CYCLES      = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUMBER_OF_SENSORS-1:0] sensor_mask,
  input  logic [31:0]                  period_cycles,
  output logic                         spi_start,
  output logic [15:0]                  spi_tx_data,
  input  logic                         spi_done,
  input  logic [15:0]                  spi_rx_data,
  output logic [NUMBER_OF_SENSORS-1:0] ss_n_o,
  input  logic [3:0]                   rd_addr,
  output logic [13:0]                  rd_angle,
  output logic [NUMBER_OF_SENSORS-1:0] error_flags,
  input  logic                         clear_errors,
  output logic [15:0]                  error_count,
  output logic                         sweep_done
);

  typedef enum logic [2:0] {
    StIdle, StSelect, StStart, StWaitDone, StHold, StNext, StWaitPeriod
  } state_e;

  localparam int unsigned SetupLast   = (SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0;
  localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_e                        state_q, state_d;
  logic [31:0]                   step_q, step_d;
  logic [31:0]                   period_q, period_d;
  logic [3:0]                    idx_q, idx_d;
  logic [13:0]                   angle_q [NUMBER_OF_SENSORS];
  logic [13:0]                   rd_angle_q;
  logic [NUMBER_OF_SENSORS-1:0]  err_flags_q;
  logic [15:0]                   err_cnt_q;

  logic       first_found, after_found;
  logic [3:0] first_idx, after_idx;
  logic       go, rx_ok, elapsed, store, err_event;

  // Lowest set mask bit overall, and lowest set bit above the current sensor.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    after_found = 1'b0;
    after_idx   = '0;
    for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
      if (sensor_mask[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = 4'(i);
      end
      if (sensor_mask[i] && !after_found && (4'(i) > idx_q)) begin
        after_found = 1'b1;
        after_idx   = 4'(i);
      end
    end
  end

  assign go      = enable && first_found;
  assign rx_ok   = !(^spi_rx_data) && !spi_rx_data[14];
  // Counter value is cycles since sweep start; "+1" makes start-to-start spacing exact.
  assign elapsed = ({1'b0, period_q} + 33'd1) >= {1'b0, period_cycles};

  always_comb begin
    state_d    = state_q;
    step_d     = step_q + 32'd1;
    idx_d      = idx_q;
    period_d   = (period_q == 32'hFFFF_FFFF) ? period_q : period_q + 32'd1;
    spi_start  = 1'b0;
    sweep_done = 1'b0;
    store      = 1'b0;
    err_event  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d  = StSelect;
          idx_d    = first_idx;
          period_d = '0;
        end
      end
      StSelect: begin
        if (step_q >= SetupLast) state_d = StStart;
      end
      StStart: begin
        spi_start = 1'b1;
        state_d   = StWaitDone;
      end
      StWaitDone: begin
        if (spi_done) begin
          state_d   = StHold;
          store     = rx_ok;
          err_event = !rx_ok;
        end else if (step_q >= TimeoutLast) begin
          state_d   = StHold;
          err_event = 1'b1;
        end
      end
      StHold: begin
        if (step_q >= SetupLast) state_d = StNext;
      end
      StNext: begin
        if (!go) begin
          state_d = StIdle;
        end else if (after_found) begin
          state_d = StSelect;
          idx_d   = after_idx;
        end else begin
          sweep_done = 1'b1;
          state_d    = StWaitPeriod;
        end
      end
      StWaitPeriod: begin
        if (!go) begin
          state_d = StIdle;
        end else if (elapsed) begin
          state_d  = StSelect;
          idx_d    = first_idx;
          period_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) step_d = '0;
  end

  always_comb begin
    ss_n_o = '1;
    if (state_q inside {StSelect, StStart, StWaitDone, StHold}) begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        if (idx_q == 4'(i)) ss_n_o[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      step_q      <= '0;
      period_q    <= '0;
      idx_q       <= '0;
      angle_q     <= '{default: '0};
      rd_angle_q  <= '0;
      err_flags_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      if (store) angle_q[idx_q] <= spi_rx_data[13:0];
      if (clear_errors) begin
        err_flags_q <= '0;
        err_cnt_q   <= '0;
      end else if (err_event) begin
        err_flags_q[idx_q] <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
      rd_angle_q <= (32'(rd_addr) < NUMBER_OF_SENSORS) ? angle_q[rd_addr] : 14'd0;
    end
  end

  assign spi_tx_data = 16'hFFFF;
  assign rd_angle    = rd_angle_q;
  assign error_flags = err_flags_q;
  assign error_count = err_cnt_q;

endmodule
